regfile_param: RTL
==================

# regfile_param

Parametrised register file for the 19-bit CPU datapath, successor to the fixed 8×19 file. It sits between decode and execute and provides:
- two combinational read ports with write-to-read bypass;
- one synchronous write port, with entry 0 hard-wired to zero;
- a per-entry busy scoreboard for in-flight results;
- a hardware clear sweep that zeroes every entry after reset or on request, replacing simulation-only initial values.

## Interface
- DATA_W, 19, data width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, 1: entry 0 reads as zero and ignores writes; 0: entry 0 is an ordinary register
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- clr_req  input  1  one-cycle pulse requesting a full clear sweep
- ready  output  1  high when the file accepts writes and returns stored data
- a1, a2  input  ADDR_W  read addresses
- rd1, rd2  output  DATA_W  read data
- a3  input  ADDR_W  write address
- we3  input  1  write enable
- wd3  input  DATA_W  write data
- set_en  input  1  mark entry set_addr busy (instruction issued)
- set_addr  input  ADDR_W  entry to mark busy
- busy1, busy2  output  1  busy bit of entry a1 / a2

## Operation
- States: CLEAR and READY. Counter cnt is ADDR_W bits wide.
- Reset assertion (rst=0), immediately and asynchronously:
  - state=CLEAR, cnt=0, ready=0, all busy bits=0;
  - rd1/rd2=0, busy1/busy2=0;
  - array contents are not reset directly; the sweep clears them.
- CLEAR state:
  - each edge writes 0 to entry cnt, then cnt increments;
  - at the edge where cnt==DEPTH-1, go to READY, set ready=1, set cnt=0;
  - we3, set_en and clr_req are ignored;
  - rd1/rd2 return 0 and busy1/busy2 return 0.
- READY state:
  - write: if we3 and not (ZERO_REG and a3==0), entry a3 <= wd3 at the edge.
  - read: rdN = 0 if ZERO_REG and aN==0. Otherwise, if we3 and aN==a3 (write accepted), rdN = wd3 (bypass). Otherwise rdN = entry[aN].
  - scoreboard: an accepted write clears busy[a3]; set_en sets busy[set_addr].
  - set_en with ZERO_REG and set_addr==0 is ignored; busy[0] stays 0.
  - set and clear of the same entry in the same cycle: busy ends at 1 (the newer producer wins).
  - busyN is combinational from busy[aN]. It is not bypassed: a write in the current cycle still shows busy until the edge.
  - clr_req: at the next edge go to CLEAR, ready=0, cnt=0, all busy=0. A write presented in that same cycle is discarded.
- Reset asserted mid-sweep restarts the sweep from entry 0.

## Timing
- Read latency is 0 cycles (combinational); write latency is 1 edge.
- After rst deasserts, ready rises after exactly DEPTH rising edges (8 at defaults).
- clr_req in READY: ready falls at the next edge and rises again DEPTH edges later, for DEPTH+1 edges total.
- Bypass path: wd3 → rdN within the same cycle. There is no registered read path.
- Outputs at reset: ready=0, rd1=rd2=0, busy1=busy2=0.

## Test plan
- Reset sweep: rst low 3 cycles, then high. ready=0 for 8 edges, 1 after edge 8; all of a1=0..7 read 0.
- Write/read/zero: write 19'h7FFFF to entry 5, then 19'h12345 to entry 0. Next cycle a1=5 reads 19'h7FFFF; a2=0 reads 0.
- Bypass: in one cycle, we3=1, a3=3, wd3=19'h00ABC, a1=3. rd1=19'h00ABC in that same cycle; entry 3 holds it after the edge.
- Scoreboard:
  - set_en with set_addr=4 → busy1=1 at a1=4;
  - a write to 4 clears it;
  - set_en and a write to 4 in the same cycle leave busy=1;
  - set_en to 0 leaves busy[0]=0.
- Clear request: fill entries 1..7 with 19'h1, then pulse clr_req. Writes during the sweep are ignored; after ready returns (9 edges) all entries read 0.
- Reset mid-operation: assert rst at cnt=4 mid-sweep. Outputs zero immediately; after release, ready rises exactly 8 edges later.

Source files
------------

// File: rtl/regfile_param_if.sv
// regfile_param_if -- bundle of the register file's decode/execute-side signals.
//   master (decode/execute side): drives clr_req, a1, a2, a3, we3, wd3,
//                                 set_en, set_addr; observes ready, rd1,
//                                 rd2, busy1, busy2.
//   slave  (register file):       the mirror image of master.
// DATA_W / ADDR_W must match the parameters of the attached regfile_param.
interface regfile_param_if #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 3
);
  logic              clr_req;
  logic              ready;
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [ADDR_W-1:0] a3;
  logic              we3;
  logic [DATA_W-1:0] wd3;
  logic              set_en;
  logic [ADDR_W-1:0] set_addr;
  logic              busy1;
  logic              busy2;

  modport master (
    output clr_req, a1, a2, a3, we3, wd3, set_en, set_addr,
    input  ready, rd1, rd2, busy1, busy2
  );

  modport slave (
    input  clr_req, a1, a2, a3, we3, wd3, set_en, set_addr,
    output ready, rd1, rd2, busy1, busy2
  );
endinterface

// File: rtl/regfile_param.sv
// regfile_param -- parametrised register file for the CPU datapath.
//   Two combinational read ports with write-to-read bypass, one synchronous
//   write port (entry 0 optionally hard-wired to zero), a per-entry busy
//   scoreboard, and a hardware clear sweep that zeroes every entry after
//   reset or on clr_req.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - asynchronous active-low reset
//   bus  - regfile_param_if.slave: read ports (a1/rd1/busy1, a2/rd2/busy2),
//          write port (a3/we3/wd3), scoreboard set (set_en/set_addr),
//          clr_req request and ready status.
module regfile_param #(
  parameter int DATA_W   = 19,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  regfile_param_if.slave  bus
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [DEPTH-1:0]  busy_reg, busy_next;

  // Storage has no reset; the clear sweep is what zeroes it.
  logic [DATA_W-1:0] mem [DEPTH];

  logic              is_ready;
  logic              wr_ok;
  logic              set_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign is_ready = (state_reg == READY);

  // A write presented alongside clr_req is dropped, so it neither updates
  // the array nor shows up on the bypass path.
  assign wr_ok  = is_ready && bus.we3 && !bus.clr_req &&
                  !(ZERO_EN && (bus.a3 == '0));
  assign set_ok = is_ready && bus.set_en && !bus.clr_req &&
                  !(ZERO_EN && (bus.set_addr == '0));

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
      busy_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= busy_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    busy_next  = busy_reg;
    case (state_reg)
      CLEAR: begin
        busy_next = '0;
        cnt_next  = cnt_reg + 1'b1;
        if (&cnt_reg) begin
          state_next = READY;
          cnt_next   = '0;
        end
      end
      READY: begin
        if (bus.clr_req) begin
          state_next = CLEAR;
          cnt_next   = '0;
          busy_next  = '0;
        end else begin
          // Clear first, then set: a same-cycle set on the entry wins.
          if (wr_ok)  busy_next[bus.a3]       = 1'b0;
          if (set_ok) busy_next[bus.set_addr] = 1'b1;
        end
      end
      default: begin
        state_next = CLEAR;
        cnt_next   = '0;
        busy_next  = '0;
      end
    endcase
  end

  // ---------------- array write port ----------------
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.a3;
    mem_wdata = bus.wd3;
    if (state_reg == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_reg;
      mem_wdata = '0;
    end else if (wr_ok) begin
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // ---------------- read ports ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr = (gi == 0) ? bus.a1 : bus.a2;

    always_comb begin
      data = '0;
      if (is_ready && !(ZERO_EN && (addr == '0))) begin
        if (wr_ok && (addr == bus.a3)) data = bus.wd3;
        else                           data = mem[addr];
      end
    end

    // Busy is deliberately not bypassed: it drops only after the write edge.
    assign busy = is_ready && busy_reg[addr];
  end

  assign bus.rd1   = g_rd[0].data;
  assign bus.rd2   = g_rd[1].data;
  assign bus.busy1 = g_rd[0].busy;
  assign bus.busy2 = g_rd[1].busy;
  assign bus.ready = is_ready;

endmodule
